// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing the UART TX FIFO write port
// Grants are held for a whole message (until req_last) or until MAX_BURST bytes are written.
module uart_tx_arbiter #(
    parameter int N_REQ     = 2,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        req_ack,
    output logic                    fifo_w_en,
    output logic [DATA_W-1:0]       fifo_w_data,
    input  logic                    fifo_full,
    output logic                    busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {IDLE, OWN} state_t;

    state_t           state, state_nxt;
    idx_t             owner, owner_nxt;
    idx_t             last_owner, last_owner_nxt;
    idx_t             pick;
    logic [7:0]       burst_cnt, burst_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic             release_now;
    logic [DATA_W-1:0] lane [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign busy        = (state == OWN);
    assign fifo_w_data = lane[owner];
    assign fifo_w_en   = busy & req[owner] & ~fifo_full;
    assign req_ack     = gnt & {N_REQ{fifo_w_en}};

    // Scan from farthest to nearest so the nearest requester after last_owner wins.
    always_comb begin
        int   c;
        idx_t cand;
        pick = '0;
        c    = 0;
        cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            c = int'(last_owner) + k;
            if (c >= N_REQ) c = c - N_REQ;
            cand = idx_t'(c);
            if (req[cand]) pick = cand;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        burst_nxt      = burst_cnt;
        gnt_nxt        = gnt;
        release_now    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt     = OWN;
                    owner_nxt     = pick;
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    burst_nxt     = 8'd0;
                end
            end
            OWN: begin
                if (!req[owner]) begin
                    release_now = 1'b1;
                end else if (fifo_w_en) begin
                    burst_nxt = burst_cnt + 8'd1;
                    if (req_last[owner] || (burst_cnt + 8'd1 == 8'(MAX_BURST)))
                        release_now = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (release_now) begin
            state_nxt      = IDLE;
            gnt_nxt        = '0;
            last_owner_nxt = owner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= idx_t'(N_REQ - 1);
            burst_cnt  <= 8'd0;
            gnt        <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_nxt;
            gnt        <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
// Vectors hold inputs for one cycle and the outputs expected before the next rising edge.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, req_last, gnt, req_ack;
    logic [15:0] req_data;
    logic        fifo_w_en, fifo_full, busy;
    logic [7:0]  fifo_w_data;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.N_REQ(2), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .gnt         (gnt),
        .req_ack     (req_ack),
        .fifo_w_en   (fifo_w_en),
        .fifo_w_data (fifo_w_data),
        .fifo_full   (fifo_full),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  req;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [1:0]  last;
        logic        full;
        logic [13:0] exp;
    } vec_t;

    // exp packs {gnt, fifo_w_en, fifo_w_data, req_ack, busy}
    function automatic vec_t mk(input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [1:0] l, input logic f, input logic [1:0] g,
                                input logic w, input logic [7:0] d, input logic [1:0] a,
                                input logic b);
        vec_t v;
        v.req  = r;
        v.d0   = d0;
        v.d1   = d1;
        v.last = l;
        v.full = f;
        v.exp  = {g, w, d, a, b};
        return v;
    endfunction

    function automatic logic [13:0] obs();
        return {gnt, fifo_w_en, fifo_w_data, req_ack, busy};
    endfunction

    task automatic drive(input vec_t v);
        req       = v.req;
        req_data  = {v.d1, v.d0};
        req_last  = v.last;
        fifo_full = v.full;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 2'b11;
        req_data  = 16'hA55A;
        req_last  = 2'b00;
        fifo_full = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs() !== {2'b00, 1'b0, 8'h5A, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", obs(), {2'b00, 1'b0, 8'h5A, 2'b00, 1'b0});
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        req      = '0;
        req_data = '0;
        @(negedge clk);
        checks++;
        if (obs() !== 14'h0) begin
            errors++;
            $display("FAIL reset_idle got %h want %h", obs(), 14'h0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        vec_t v[$];
        apply_reset();
        v.push_back(mk(2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b00, 0, 8'h41, 2'b00, 0));
        v.push_back(mk(2'b01, 8'h41, 8'h00, 2'b00, 0, 2'b01, 1, 8'h41, 2'b01, 1));
        v.push_back(mk(2'b01, 8'h42, 8'h00, 2'b00, 0, 2'b01, 1, 8'h42, 2'b01, 1));
        v.push_back(mk(2'b01, 8'h43, 8'h00, 2'b01, 0, 2'b01, 1, 8'h43, 2'b01, 1));
        v.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        v.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL single[%0d] got %h want %h", i, obs(), v[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        vec_t v[$];
        apply_reset();
        v.push_back(mk(2'b11, 8'h01, 8'h11, 2'b00, 0, 2'b00, 0, 8'h01, 2'b00, 0));
        v.push_back(mk(2'b11, 8'h01, 8'h11, 2'b00, 0, 2'b01, 1, 8'h01, 2'b01, 1));
        v.push_back(mk(2'b11, 8'h02, 8'h11, 2'b01, 0, 2'b01, 1, 8'h02, 2'b01, 1));
        v.push_back(mk(2'b11, 8'h03, 8'h11, 2'b00, 0, 2'b00, 0, 8'h03, 2'b00, 0));
        v.push_back(mk(2'b11, 8'h03, 8'h11, 2'b00, 0, 2'b10, 1, 8'h11, 2'b10, 1));
        v.push_back(mk(2'b11, 8'h03, 8'h12, 2'b10, 0, 2'b10, 1, 8'h12, 2'b10, 1));
        v.push_back(mk(2'b01, 8'h03, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        v.push_back(mk(2'b01, 8'h03, 8'h00, 2'b00, 0, 2'b01, 1, 8'h03, 2'b01, 1));
        v.push_back(mk(2'b01, 8'h04, 8'h00, 2'b01, 0, 2'b01, 1, 8'h04, 2'b01, 1));
        v.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL round_robin[%0d] got %h want %h", i, obs(), v[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        vec_t v[$];
        apply_reset();
        v.push_back(mk(2'b01, 8'h21, 8'h00, 2'b00, 0, 2'b00, 0, 8'h21, 2'b00, 0));
        v.push_back(mk(2'b01, 8'h21, 8'h00, 2'b00, 0, 2'b01, 1, 8'h21, 2'b01, 1));
        for (int s = 0; s < 5; s++)
            v.push_back(mk(2'b01, 8'h22, 8'h00, 2'b00, 1, 2'b01, 0, 8'h22, 2'b00, 1));
        v.push_back(mk(2'b01, 8'h22, 8'h00, 2'b00, 0, 2'b01, 1, 8'h22, 2'b01, 1));
        v.push_back(mk(2'b01, 8'h23, 8'h00, 2'b00, 0, 2'b01, 1, 8'h23, 2'b01, 1));
        v.push_back(mk(2'b01, 8'h24, 8'h00, 2'b00, 0, 2'b01, 1, 8'h24, 2'b01, 1));
        v.push_back(mk(2'b01, 8'h25, 8'h00, 2'b01, 0, 2'b00, 0, 8'h25, 2'b00, 0));
        v.push_back(mk(2'b01, 8'h25, 8'h00, 2'b01, 0, 2'b01, 1, 8'h25, 2'b01, 1));
        v.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL stall[%0d] got %h want %h", i, obs(), v[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_burst_limit();
        vec_t v[$];
        apply_reset();
        v.push_back(mk(2'b10, 8'h00, 8'h31, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        v.push_back(mk(2'b11, 8'h0A, 8'h31, 2'b01, 0, 2'b10, 1, 8'h31, 2'b10, 1));
        v.push_back(mk(2'b11, 8'h0A, 8'h32, 2'b01, 0, 2'b10, 1, 8'h32, 2'b10, 1));
        v.push_back(mk(2'b11, 8'h0A, 8'h33, 2'b01, 0, 2'b10, 1, 8'h33, 2'b10, 1));
        v.push_back(mk(2'b11, 8'h0A, 8'h34, 2'b01, 0, 2'b10, 1, 8'h34, 2'b10, 1));
        v.push_back(mk(2'b11, 8'h0A, 8'h35, 2'b01, 0, 2'b00, 0, 8'h35, 2'b00, 0));
        v.push_back(mk(2'b11, 8'h0A, 8'h35, 2'b01, 0, 2'b01, 1, 8'h0A, 2'b01, 1));
        v.push_back(mk(2'b10, 8'h00, 8'h35, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        v.push_back(mk(2'b10, 8'h00, 8'h35, 2'b00, 0, 2'b10, 1, 8'h35, 2'b10, 1));
        v.push_back(mk(2'b10, 8'h00, 8'h36, 2'b10, 0, 2'b10, 1, 8'h36, 2'b10, 1));
        v.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL burst_limit[%0d] got %h want %h", i, obs(), v[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_abandon();
        vec_t v[$];
        apply_reset();
        v.push_back(mk(2'b11, 8'h51, 8'h61, 2'b10, 0, 2'b00, 0, 8'h51, 2'b00, 0));
        v.push_back(mk(2'b11, 8'h51, 8'h61, 2'b10, 0, 2'b01, 1, 8'h51, 2'b01, 1));
        v.push_back(mk(2'b10, 8'h00, 8'h61, 2'b10, 0, 2'b01, 0, 8'h00, 2'b00, 1));
        v.push_back(mk(2'b10, 8'h00, 8'h61, 2'b10, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        v.push_back(mk(2'b10, 8'h00, 8'h61, 2'b10, 0, 2'b10, 1, 8'h61, 2'b10, 1));
        v.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL abandon[%0d] got %h want %h", i, obs(), v[i].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_burst();
        vec_t v[$];
        apply_reset();
        v.push_back(mk(2'b01, 8'h71, 8'h00, 2'b01, 0, 2'b00, 0, 8'h71, 2'b00, 0));
        v.push_back(mk(2'b01, 8'h71, 8'h00, 2'b01, 0, 2'b01, 1, 8'h71, 2'b01, 1));
        v.push_back(mk(2'b10, 8'h00, 8'h81, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        v.push_back(mk(2'b10, 8'h00, 8'h81, 2'b00, 0, 2'b10, 1, 8'h81, 2'b10, 1));
        v.push_back(mk(2'b10, 8'h00, 8'h82, 2'b00, 0, 2'b10, 1, 8'h82, 2'b10, 1));
        v.push_back(mk(2'b11, 8'h91, 8'h82, 2'b11, 0, 2'b00, 0, 8'h91, 2'b00, 0));
        v.push_back(mk(2'b11, 8'h91, 8'h82, 2'b11, 0, 2'b01, 1, 8'h91, 2'b01, 1));
        v.push_back(mk(2'b10, 8'h00, 8'h82, 2'b10, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        v.push_back(mk(2'b10, 8'h00, 8'h82, 2'b10, 0, 2'b10, 1, 8'h82, 2'b10, 1));
        v.push_back(mk(2'b00, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 8'h00, 2'b00, 0));
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            checks++;
            if (obs() !== v[i].exp) begin
                errors++;
                $display("FAIL reset_mid[%0d] got %h want %h", i, obs(), v[i].exp);
            end
            if (i == 4) begin
                // Reset lands between edges; outputs must drop without waiting for a clock.
                #1;
                rst_n = 1'b0;
                #1;
                checks++;
                if (obs() !== 14'h0) begin
                    errors++;
                    $display("FAIL reset_mid_async got %h want %h", obs(), 14'h0);
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_burst_limit();
        test_abandon();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the UART TX FIFO write port among several byte-stream requesters, such as the Wishbone control path and hardware message sources. A grant is held for a whole message until the requester marks its last byte, so bytes from different requesters never interleave. A burst limit stops one requester from monopolising the port. The block sits between the requesters and the TX FIFO write interface (w_en / w_data / full) that feeds uart_transmission.

## Interface
- N_REQ, 2, number of requesters (2..4)
- DATA_W, 8, byte width of the FIFO write data
- MAX_BURST, 16, maximum bytes written per grant before a forced release (1..255)

- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester "byte available" level
- req_data  in  N_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  qualifies the current byte of requester i as the message's last byte
- gnt  out  N_REQ  one-hot registered grant; all zero when idle
- req_ack  out  N_REQ  one-cycle pulse: requester i's current byte was written this cycle
- fifo_w_en  out  1  TX FIFO write enable
- fifo_w_data  out  DATA_W  TX FIFO write data
- fifo_full  in  1  TX FIFO full
- busy  out  1  high while a grant is held (state OWN)

## Operation
- Two states: IDLE and OWN.
- Registers:
  - owner (index)
  - last_owner (index)
  - burst_cnt (8 bits)
  - gnt
- Reset values:
  - state=IDLE, gnt=0, busy=0, owner=0, burst_cnt=0.
  - last_owner=N_REQ-1, so requester 0 has first priority.
  - fifo_w_en=0 and req_ack=0 follow from gnt=0.

IDLE:
- If any req bit is set, the next state is OWN.
- owner becomes the first index with req set, searching from last_owner+1 and wrapping modulo N_REQ.
- gnt is set to one-hot(owner) and burst_cnt is cleared.
- If no req bit is set, stay in IDLE.

OWN:
- Combinational write: fifo_w_en = req[owner] & ~fifo_full.
- fifo_w_data = req_data slice of owner, always driven from the owner index, including in IDLE.
- req_ack = gnt & {N_REQ{fifo_w_en}}.
- On each write, burst_cnt increments.
- Release happens when any of the following occurs. On release the next state is IDLE, gnt is cleared and last_owner is set to owner.
  - A write occurs with req_last[owner]=1.
  - A write occurs and burst_cnt+1 == MAX_BURST (forced release; the message continues on the next grant).
  - req[owner]=0 (requester abandoned; no write that cycle).
- fifo_full=1 with req[owner]=1 is a stall: no write, no ack, counter held, grant kept. There is no timeout on a stall.
- Requests from non-owners are ignored while in OWN. They are evaluated in the IDLE cycle after release.

General rules:
- Requesters must hold req, req_data and req_last stable until they see ack.
- Requester bits that are not granted never produce an ack.
- Multiple simultaneous requests resolve in rotating order. Each requester waits at most N_REQ-1 other grants.

## Timing
- Grant latency: req rising in IDLE at edge k gives gnt valid after edge k+1. The first write can occur in that same cycle (k+1).
- Throughput: one byte per cycle while owning with fifo_full=0.
- Release costs exactly one IDLE cycle between grants (bus idle, fifo_w_en=0).
- fifo_w_en, fifo_w_data and req_ack are combinational from registered state plus req, req_last and fifo_full. There is no combinational path from fifo_full to gnt.
- Asserting rst_n mid-burst clears gnt and busy immediately (asynchronously). A partially sent message is abandoned; the requester restarts it after a new grant.

## Test plan
- Single requester 0 sends 0x41,0x42,0x43 with last on 0x43 and fifo_full=0: gnt=01 one cycle after req, three consecutive fifo_w_en pulses with data 41,42,43, then busy=0 for one cycle.
- Requesters 0 and 1 both request from reset, each with a 2-byte message: order is 0 then 1 then 0; one idle cycle between grants; no interleaving.
- fifo_full held high for 5 cycles mid-message: no writes or acks during the stall, gnt held, bytes resume in order once full drops, byte count unchanged.
- MAX_BURST=4 with a 6-byte message from requester 1 while requester 0 also waits: 4 bytes written, forced release, requester 0 is granted, then requester 1's remaining 2 bytes follow.
- Requester drops req after 1 byte with no last: release next cycle, last_owner updated, next requester granted.
- rst_n pulsed low during the 2nd byte of a burst: gnt=0, fifo_w_en=0 immediately; after release the requester 0 priority order is restored.
